// File: rtl/pifo_pkg.sv
// pifo_pkg: shared types and default widths for the PIFO root arbiter.
// Exports state_t, pifo_data_t, TREE_ID_W, ADW, CNTW and DEF_* defaults.
package pifo_pkg;

  localparam int DEF_TREE_NUM = 4;
  localparam int DEF_PTW      = 16;
  localparam int DEF_MTW      = 0;
  localparam int DEF_LEVEL    = 4;
  localparam int DEF_CAP      = 2 * ((1 << DEF_LEVEL) - 1);

  localparam int TREE_ID_W = $clog2(DEF_TREE_NUM);
  localparam int ADW       = DEF_LEVEL - 1;
  localparam int CNTW      = $clog2(DEF_CAP + 1);
  localparam int DATA_W    = DEF_MTW + DEF_PTW;

  typedef logic [DATA_W-1:0] pifo_data_t;

  typedef enum logic {
    ST_READY,
    ST_POP_WAIT
  } state_t;

endpackage

// File: rtl/pifo_root_arbiter_rr.sv
// rr_arbiter: round-robin pick of the first request at or above i_ptr.
// Ports: i_req, i_ptr in; o_gnt one-hot, o_idx, o_any out. N power of 2.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_ptr,
  output logic [N-1:0]  o_gnt,
  output logic [IW-1:0] o_idx,
  output logic          o_any
);

  logic [IW-1:0] cand;

  // Walk offsets high to low so the smallest
  // offset from the pointer is the final winner.
  always_comb begin
    o_gnt = '0;
    o_idx = '0;
    o_any = 1'b0;
    cand  = '0;
    for (int k = N - 1; k >= 0; k--) begin
      cand = i_ptr + IW'(k);
      if (i_req[cand]) begin
        o_idx = cand;
        o_any = 1'b1;
      end
    end
    if (o_any) o_gnt[o_idx] = 1'b1;
  end

endmodule

// File: rtl/pifo_root_arbiter.sv
// pifo_root_arbiter: shares the root PIFO level among TREE_NUM trees.
// Ports: per-tree push/pop requests and acks, root level cmd bus, pop result.
module pifo_root_arbiter
  import pifo_pkg::*;
#(
  parameter int TREE_NUM = DEF_TREE_NUM,
  parameter int PTW      = DEF_PTW,
  parameter int MTW      = DEF_MTW,
  parameter int LEVEL    = DEF_LEVEL,
  parameter int CAP      = 2 * ((1 << LEVEL) - 1),
  parameter int CNT_W    = $clog2(CAP + 1)
) (
  input  logic                          i_clk,
  input  logic                          i_arst,
  input  logic [TREE_NUM-1:0]           i_req_push,
  input  logic [TREE_NUM-1:0]           i_req_pop,
  input  logic [TREE_NUM*(MTW+PTW)-1:0] i_req_data,
  output logic [TREE_NUM-1:0]           o_req_ack,
  output logic                          o_pop_valid,
  output logic [$clog2(TREE_NUM)-1:0]   o_pop_tree_id,
  output logic [MTW+PTW-1:0]            o_pop_data,
  output logic                          o_push,
  output logic                          o_pop,
  output logic [MTW+PTW-1:0]            o_push_data,
  output logic [$clog2(TREE_NUM)-1:0]   o_tree_id,
  output logic [LEVEL-2:0]              o_my_addr,
  output logic [$clog2(LEVEL)-1:0]      o_level,
  input  logic [MTW+PTW-1:0]            i_pop_data,
  output logic [TREE_NUM-1:0]           o_tree_empty,
  output logic [TREE_NUM-1:0]           o_tree_full
);

  localparam int IDW = $clog2(TREE_NUM);
  localparam int PW  = MTW + PTW;

  state_t           st_q;
  state_t           st_d;
  logic [CNT_W-1:0] cnt_q [TREE_NUM];
  logic [PW-1:0]    slice [TREE_NUM];
  logic [IDW-1:0]   ptr_q;
  logic [IDW-1:0]   pop_id_q;

  logic [TREE_NUM-1:0] elig;
  logic [TREE_NUM-1:0] gnt;
  logic [IDW-1:0]      idx;
  logic                any;
  logic                take;
  logic                is_pop;

  always_comb begin
    for (int t = 0; t < TREE_NUM; t++) begin
      slice[t] = i_req_data[t*PW +: PW];
      elig[t] =
        (i_req_pop[t] & (cnt_q[t] != '0)) |
        (i_req_push[t] & (cnt_q[t] != CNT_W'(CAP)));
      o_tree_empty[t] = (cnt_q[t] == '0);
      o_tree_full[t]  = (cnt_q[t] == CNT_W'(CAP));
    end
  end

  rr_arbiter #(
    .N (TREE_NUM)
  ) u_rr (
    .i_req (elig),
    .i_ptr (ptr_q),
    .o_gnt (gnt),
    .o_idx (idx),
    .o_any (any)
  );

  assign o_my_addr = '0;
  assign o_level   = '0;

  // Commands are combinational from the grant; reset
  // masks them so nothing leaks out while held.
  always_comb begin
    st_d        = st_q;
    take        = 1'b0;
    is_pop      = 1'b0;
    o_push      = 1'b0;
    o_pop       = 1'b0;
    o_req_ack   = '0;
    o_tree_id   = '0;
    o_push_data = '0;
    unique case (st_q)
      ST_READY: begin
        if (any && !i_arst) begin
          take      = 1'b1;
          // pop wins over push from the same tree
          is_pop    = i_req_pop[idx] &&
                      (cnt_q[idx] != '0);
          o_pop     = is_pop;
          o_push    = !is_pop;
          o_req_ack = gnt;
          o_tree_id = idx;
          if (is_pop) st_d = ST_POP_WAIT;
          else o_push_data = slice[idx];
        end
      end
      ST_POP_WAIT: st_d = ST_READY;
      default:     st_d = ST_READY;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_arst) begin
    if (i_arst) st_q <= ST_READY;
    else        st_q <= st_d;
  end

  always_ff @(posedge i_clk or posedge i_arst) begin
    if (i_arst) begin
      ptr_q         <= '0;
      pop_id_q      <= '0;
      o_pop_valid   <= 1'b0;
      o_pop_data    <= '0;
      o_pop_tree_id <= '0;
      for (int t = 0; t < TREE_NUM; t++)
        cnt_q[t] <= '0;
    end else begin
      // the level presents its pop data during the wait cycle
      o_pop_valid <= (st_q == ST_POP_WAIT);
      if (st_q == ST_POP_WAIT) begin
        o_pop_data    <= i_pop_data;
        o_pop_tree_id <= pop_id_q;
      end
      if (take) begin
        ptr_q <= idx + 1'b1;
        if (is_pop) begin
          cnt_q[idx] <= cnt_q[idx] - 1'b1;
          pop_id_q   <= idx;
        end else begin
          cnt_q[idx] <= cnt_q[idx] + 1'b1;
        end
      end
    end
  end

endmodule
